oldland_memory_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage; consumes its registered memory-control and writeback outputs.
- Runs loads and stores on the data bus with a request/ack handshake, and stalls the pipeline while an access is outstanding.
- Aligns and zero-extends load data and forwards the writeback register, value and enable to the register file.
- Has a bus-timeout watchdog that aborts a hung access.

---
 rtl/oldland_memory_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_oldland_memory_stage.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oldland_memory_stage.sv
// oldland_memory_stage: memory stage that sits directly after the execute stage.
// Runs loads/stores on the data bus with a request/ack handshake, stalls the
// pipeline while an access is outstanding, aligns and zero-extends load data
// and forwards the writeback register/value/enable to the register file.
// A watchdog aborts a bus access that is never acknowledged.
//
// Optional build macro: OLDLAND_MEM_ALIGN_CHECK_EN -- when defined, accesses
// misaligned for their width raise bus_error instead of reaching the bus.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   mem_load/mem_store           memory op request from execute
//   mem_width                    00=32b, 01=16b, 10=8b, 11=32b
//   mar, mdr                     byte address, right-justified store data
//   wr_val, wr_result, rd_sel    non-load writeback value / enable / register
//   d_addr, d_bytesel, d_wr_en,
//   d_wr_val, d_access           data bus request (registered)
//   d_data, d_ack                data bus response
//   stall                        combinational hold for upstream stages
//   wb_en, wb_sel, wb_val        register file writeback (registered)
//   bus_error                    one-cycle pulse on abort
module oldland_memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [1:0]  mem_width,
  input  logic [31:0] mar,
  input  logic [31:0] mdr,
  input  logic [31:0] wr_val,
  input  logic        wr_result,
  input  logic [2:0]  rd_sel,
  output logic [31:0] d_addr,
  output logic [3:0]  d_bytesel,
  output logic        d_wr_en,
  output logic [31:0] d_wr_val,
  output logic        d_access,
  input  logic [31:0] d_data,
  input  logic        d_ack,
  output logic        stall,
  output logic        wb_en,
  output logic [2:0]  wb_sel,
  output logic [31:0] wb_val,
  output logic        bus_error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]  W_16  = 2'b01;
  localparam logic [1:0]  W_8   = 2'b10;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_store_q, is_store_d;
  logic [1:0]         width_q, width_d;
  logic [1:0]         lane_q, lane_d;
  logic [2:0]         rd_sel_q, rd_sel_d;
  logic               wr_result_q, wr_result_d;
  logic [31:0]        d_addr_q, d_addr_d;
  logic [3:0]         d_bytesel_q, d_bytesel_d;
  logic               d_wr_en_q, d_wr_en_d;
  logic [31:0]        d_wr_val_q, d_wr_val_d;
  logic               d_access_q, d_access_d;
  logic               wb_en_q, wb_en_d;
  logic [2:0]         wb_sel_q, wb_sel_d;
  logic [31:0]        wb_val_q, wb_val_d;
  logic               bus_error_q, bus_error_d;

  logic               mem_op_c;
  logic               misaligned_c;
  logic               timeout_c;

  // Byte-lane enables for a given width and low address bits.
  function automatic logic [3:0] lanes_f(input logic [1:0] w, input logic [1:0] a);
    case (w)
      W_16:    lanes_f = a[1] ? 4'b1100 : 4'b0011;
      W_8:     lanes_f = 4'b0001 << a;
      default: lanes_f = 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data across every lane it may land on.
  function automatic logic [31:0] store_data_f(input logic [1:0] w, input logic [31:0] d);
    case (w)
      W_16:    store_data_f = {2{d[15:0]}};
      W_8:     store_data_f = {4{d[7:0]}};
      default: store_data_f = d;
    endcase
  endfunction

  // Shift the addressed lane down and zero-extend it.
  function automatic logic [31:0] load_data_f(input logic [1:0] w, input logic [1:0] a,
                                              input logic [31:0] d);
    logic [31:0] sh8;
    logic [31:0] sh16;
    sh8  = d >> {a, 3'b000};
    sh16 = d >> {a[1], 4'b0000};
    case (w)
      W_16:    load_data_f = 32'(sh16[15:0]);
      W_8:     load_data_f = 32'(sh8[7:0]);
      default: load_data_f = d;
    endcase
  endfunction

  assign mem_op_c = mem_load | mem_store;

`ifdef OLDLAND_MEM_ALIGN_CHECK_EN
  // Width-dependent alignment check; byte accesses can never be misaligned.
  always_comb begin
    misaligned_c = 1'b0;
    case (mem_width)
      W_16:    misaligned_c = mar[0];
      W_8:     misaligned_c = 1'b0;
      default: misaligned_c = (mar[1:0] != 2'b00);
    endcase
  end
`else
  assign misaligned_c = 1'b0;
`endif

  // Counter holds the number of completed WAIT cycles; abort on the last one.
  assign timeout_c = (TIMEOUT_CYCLES != 0) &&
                     ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

  // Hold upstream while an access is issuing or outstanding.
  assign stall = rst_n & ((state_q == ST_WAIT) | mem_op_c);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    width_d     = width_q;
    lane_d      = lane_q;
    rd_sel_d    = rd_sel_q;
    wr_result_d = wr_result_q;
    d_addr_d    = d_addr_q;
    d_bytesel_d = d_bytesel_q;
    d_wr_en_d   = d_wr_en_q;
    d_wr_val_d  = d_wr_val_q;
    d_access_d  = d_access_q;
    wb_en_d     = wb_en_q;
    wb_sel_d    = wb_sel_q;
    wb_val_d    = wb_val_q;
    bus_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (mem_op_c) begin
          wb_en_d = 1'b0;
          if (misaligned_c) begin
            bus_error_d = 1'b1;
          end else begin
            // Store wins when both load and store are requested.
            is_store_d  = mem_store;
            width_d     = mem_width;
            lane_d      = mar[1:0];
            rd_sel_d    = rd_sel;
            wr_result_d = wr_result;
            d_addr_d    = {mar[31:2], 2'b00};
            d_bytesel_d = lanes_f(mem_width, mar[1:0]);
            d_wr_en_d   = mem_store;
            d_wr_val_d  = store_data_f(mem_width, mdr);
            d_access_d  = 1'b1;
            state_d     = ST_WAIT;
          end
        end else begin
          wb_en_d  = wr_result;
          wb_sel_d = rd_sel;
          wb_val_d = wr_val;
        end
      end
      ST_WAIT: begin
        wb_en_d = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        if (d_ack) begin
          d_access_d = 1'b0;
          state_d    = ST_IDLE;
          cnt_d      = '0;
          if (!is_store_q) begin
            wb_en_d  = wr_result_q;
            wb_sel_d = rd_sel_q;
            wb_val_d = load_data_f(width_q, lane_q, d_data);
          end
        end else if (timeout_c) begin
          d_access_d  = 1'b0;
          bus_error_d = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_store_q  <= 1'b0;
      width_q     <= '0;
      lane_q      <= '0;
      rd_sel_q    <= '0;
      wr_result_q <= 1'b0;
      d_addr_q    <= '0;
      d_bytesel_q <= '0;
      d_wr_en_q   <= 1'b0;
      d_wr_val_q  <= '0;
      d_access_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_sel_q    <= '0;
      wb_val_q    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      width_q     <= width_d;
      lane_q      <= lane_d;
      rd_sel_q    <= rd_sel_d;
      wr_result_q <= wr_result_d;
      d_addr_q    <= d_addr_d;
      d_bytesel_q <= d_bytesel_d;
      d_wr_en_q   <= d_wr_en_d;
      d_wr_val_q  <= d_wr_val_d;
      d_access_q  <= d_access_d;
      wb_en_q     <= wb_en_d;
      wb_sel_q    <= wb_sel_d;
      wb_val_q    <= wb_val_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign d_addr    = d_addr_q;
  assign d_bytesel = d_bytesel_q;
  assign d_wr_en   = d_wr_en_q;
  assign d_wr_val  = d_wr_val_q;
  assign d_access  = d_access_q;
  assign wb_en     = wb_en_q;
  assign wb_sel    = wb_sel_q;
  assign wb_val    = wb_val_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_oldland_memory_stage.sv
// Self-checking bench for oldland_memory_stage (watchdog set to 4 cycles).
module tb_oldland_memory_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_load, mem_store;
  logic [1:0]  mem_width;
  logic [31:0] mar, mdr, wr_val;
  logic        wr_result;
  logic [2:0]  rd_sel;
  logic [31:0] d_addr;
  logic [3:0]  d_bytesel;
  logic        d_wr_en;
  logic [31:0] d_wr_val;
  logic        d_access;
  logic [31:0] d_data;
  logic        d_ack;
  logic        stall;
  logic        wb_en;
  logic [2:0]  wb_sel;
  logic [31:0] wb_val;
  logic        bus_error;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] val;
  } wb_t;

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] md;
    logic [31:0] dd;
    int          waits;
  } op_t;

  wb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  oldland_memory_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_load(mem_load), .mem_store(mem_store), .mem_width(mem_width),
    .mar(mar), .mdr(mdr), .wr_val(wr_val), .wr_result(wr_result), .rd_sel(rd_sel),
    .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_en(d_wr_en), .d_wr_val(d_wr_val),
    .d_access(d_access), .d_data(d_data), .d_ack(d_ack),
    .stall(stall), .wb_en(wb_en), .wb_sel(wb_sel), .wb_val(wb_val),
    .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the bus-side encoding and load extraction.
  function automatic logic [3:0] m_lanes(input logic [1:0] w, input logic [1:0] a);
    if (w == 2'b10) begin
      case (a)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (w == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wval(input logic [1:0] w, input logic [31:0] d);
    if (w == 2'b10) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (w == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] w, input logic [1:0] a,
                                         input logic [31:0] d);
    if (w == 2'b10) begin
      case (a)
        2'd0: return {24'h0, d[7:0]};
        2'd1: return {24'h0, d[15:8]};
        2'd2: return {24'h0, d[23:16]};
        default: return {24'h0, d[31:24]};
      endcase
    end
    if (w == 2'b01) return a[1] ? {16'h0, d[31:16]} : {16'h0, d[15:0]};
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_load = 1'b0; mem_store = 1'b0; mem_width = 2'b00;
    mar = '0; mdr = '0; wr_val = '0; wr_result = 1'b0; rd_sel = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    d_ack = 1'b0; d_data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({d_addr, d_bytesel, d_wr_en, d_wr_val, d_access, stall, wb_en, wb_sel, wb_val, bus_error} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: d_access=%b stall=%b wb_en=%b wb_val=%h bus_error=%b, required all 0",
               d_access, stall, wb_en, wb_val, bus_error);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({d_access, stall, wb_en, bus_error} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_release: d_access=%b stall=%b wb_en=%b bus_error=%b, required 0000",
               d_access, stall, wb_en, bus_error);
    end
  endtask

  task automatic test_nonmem();
    wb_t exp;
    tick();
    wr_result = 1'b1; rd_sel = 3'd3; wr_val = 32'h12345678;
    d_ack = 1'b1;  // stray ack in IDLE must be ignored
    sb.push_back('{sel: 3'd3, val: 32'h12345678});
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL nonmem_stall_issue: stall=%b, required 0", stall);
    end
    tick();
    idle_inputs();
    d_ack = 1'b0;
    @(negedge clk);
    exp = sb.pop_front();
    n_cmp++;
    if (wb_en !== 1'b1 || wb_sel !== exp.sel || wb_val !== exp.val) begin
      n_err++;
      $display("FAIL nonmem_wb: wb_en=%b wb_sel=%0d wb_val=%h, required 1 %0d %h",
               wb_en, wb_sel, wb_val, exp.sel, exp.val);
    end
    n_cmp++;
    if ({stall, d_access} !== 2'b00) begin
      n_err++; $display("FAIL nonmem_no_access: stall=%b d_access=%b, required 00", stall, d_access);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (wb_en !== 1'b0) begin
      n_err++; $display("FAIL nonmem_wb_clear: wb_en=%b, required 0", wb_en);
    end
  endtask

  task automatic test_load_byte();
    wb_t exp;
    tick();
    mem_load = 1'b1; mem_width = 2'b10; mar = 32'h1003; wr_result = 1'b1; rd_sel = 3'd5;
    sb.push_back('{sel: 3'd5, val: 32'h000000AA});
    @(negedge clk);
    n_cmp++;
    if ({stall, d_access} !== 2'b10) begin
      n_err++; $display("FAIL ldb_issue: stall=%b d_access=%b, required 10", stall, d_access);
    end
    tick();
    idle_inputs();
    for (int c = 0; c <= 2; c++) begin
      d_ack = (c == 2);
      d_data = (c == 2) ? 32'hAABBCCDD : 32'h0;
      @(negedge clk);
      n_cmp++;
      if ({d_access, stall, wb_en, d_wr_en} !== 4'b1100) begin
        n_err++;
        $display("FAIL ldb_wait%0d: d_access=%b stall=%b wb_en=%b d_wr_en=%b, required 1100",
                 c, d_access, stall, wb_en, d_wr_en);
      end
      if (c == 0) begin
        n_cmp++;
        if (d_addr !== 32'h1000 || d_bytesel !== 4'b1000) begin
          n_err++;
          $display("FAIL ldb_bus: d_addr=%h d_bytesel=%b, required 00001000 1000", d_addr, d_bytesel);
        end
      end
      tick();
    end
    d_ack = 1'b0;
    @(negedge clk);
    exp = sb.pop_front();
    n_cmp++;
    if (wb_en !== 1'b1 || wb_sel !== exp.sel || wb_val !== exp.val) begin
      n_err++;
      $display("FAIL ldb_wb: wb_en=%b wb_sel=%0d wb_val=%h, required 1 %0d %h",
               wb_en, wb_sel, wb_val, exp.sel, exp.val);
    end
    n_cmp++;
    if ({stall, d_access} !== 2'b00) begin
      n_err++; $display("FAIL ldb_done: stall=%b d_access=%b, required 00", stall, d_access);
    end
  endtask

  task automatic test_store_half();
    tick();
    mem_store = 1'b1; mem_width = 2'b01; mar = 32'h2002; mdr = 32'h0000BEEF;
    wr_result = 1'b1; rd_sel = 3'd2;
    @(negedge clk);
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (d_addr !== 32'h2000 || d_bytesel !== 4'b1100 || d_wr_val !== 32'hBEEFBEEF ||
        d_wr_en !== 1'b1 || d_access !== 1'b1) begin
      n_err++;
      $display("FAIL sth_bus: addr=%h bs=%b wv=%h we=%b acc=%b, required 00002000 1100 beefbeef 1 1",
               d_addr, d_bytesel, d_wr_val, d_wr_en, d_access);
    end
    d_ack = 1'b1;
    tick();
    d_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wb_en, stall, d_access, bus_error} !== 4'b0000) begin
      n_err++;
      $display("FAIL sth_done: wb_en=%b stall=%b d_access=%b bus_error=%b, required 0000",
               wb_en, stall, d_access, bus_error);
    end
  endtask

  task automatic test_width_sweep();
    op_t ops[8] = '{
      '{ld: 1'b1, st: 1'b0, w: 2'b00, a: 32'h0100, md: 32'h0, dd: 32'h11223344, waits: 0},
      '{ld: 1'b1, st: 1'b0, w: 2'b01, a: 32'h0102, md: 32'h0, dd: 32'hDEADBEEF, waits: 1},
      '{ld: 1'b1, st: 1'b0, w: 2'b01, a: 32'h0200, md: 32'h0, dd: 32'hDEADBEEF, waits: 3},
      '{ld: 1'b1, st: 1'b0, w: 2'b10, a: 32'h0301, md: 32'h0, dd: 32'h87654321, waits: 0},
      '{ld: 1'b0, st: 1'b1, w: 2'b10, a: 32'h0402, md: 32'h000000A5, dd: 32'h0, waits: 2},
      '{ld: 1'b1, st: 1'b1, w: 2'b00, a: 32'h0500, md: 32'h0BADF00D, dd: 32'h0, waits: 0},
      '{ld: 1'b1, st: 1'b0, w: 2'b11, a: 32'h0600, md: 32'h0, dd: 32'h55AA55AA, waits: 1},
      '{ld: 1'b0, st: 1'b1, w: 2'b01, a: 32'h0700, md: 32'hFFFF1234, dd: 32'h0, waits: 0}
    };
    wb_t exp;
    logic is_st;
    for (int i = 0; i < 8; i++) begin
      is_st = ops[i].st;
      tick();
      mem_load = ops[i].ld; mem_store = ops[i].st; mem_width = ops[i].w;
      mar = ops[i].a; mdr = ops[i].md; wr_result = 1'b1; rd_sel = 3'(i);
      if (!is_st) sb.push_back('{sel: 3'(i), val: m_load(ops[i].w, ops[i].a[1:0], ops[i].dd)});
      @(negedge clk);
      tick();
      idle_inputs();
      for (int c = 0; c <= ops[i].waits; c++) begin
        d_ack = (c == ops[i].waits);
        d_data = (c == ops[i].waits) ? ops[i].dd : 32'hFFFFFFFF;
        @(negedge clk);
        n_cmp++;
        if ({d_access, stall, bus_error} !== 3'b110) begin
          n_err++;
          $display("FAIL sweep%0d_wait%0d: d_access=%b stall=%b bus_error=%b, required 110",
                   i, c, d_access, stall, bus_error);
        end
        if (c == 0) begin
          n_cmp++;
          if (d_addr !== {ops[i].a[31:2], 2'b00} || d_bytesel !== m_lanes(ops[i].w, ops[i].a[1:0]) ||
              d_wr_en !== is_st || (is_st && d_wr_val !== m_wval(ops[i].w, ops[i].md))) begin
            n_err++;
            $display("FAIL sweep%0d_bus: addr=%h bs=%b we=%b wv=%h, required %h %b %b %h", i,
                     d_addr, d_bytesel, d_wr_en, d_wr_val, {ops[i].a[31:2], 2'b00},
                     m_lanes(ops[i].w, ops[i].a[1:0]), is_st, m_wval(ops[i].w, ops[i].md));
          end
        end
        tick();
      end
      d_ack = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (is_st) begin
        if ({wb_en, stall, d_access, bus_error} !== 4'b0000) begin
          n_err++;
          $display("FAIL sweep%0d_store_done: wb_en=%b stall=%b d_access=%b bus_error=%b, required 0000",
                   i, wb_en, stall, d_access, bus_error);
        end
      end else begin
        exp = sb.pop_front();
        if (wb_en !== 1'b1 || wb_sel !== exp.sel || wb_val !== exp.val ||
            {stall, d_access, bus_error} !== 3'b000) begin
          n_err++;
          $display("FAIL sweep%0d_load_wb: wb_en=%b sel=%0d val=%h st/acc/err=%b%b%b, required 1 %0d %h 000",
                   i, wb_en, wb_sel, wb_val, stall, d_access, bus_error, exp.sel, exp.val);
        end
      end
    end
  endtask

  task automatic test_timeout();
    wb_t exp;
    tick();
    mem_load = 1'b1; mem_width = 2'b00; mar = 32'h3000; wr_result = 1'b1; rd_sel = 3'd6;
    @(negedge clk);
    tick();
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({d_access, stall, bus_error} !== 3'b110) begin
        n_err++;
        $display("FAIL timeout_wait%0d: d_access=%b stall=%b bus_error=%b, required 110",
                 c, d_access, stall, bus_error);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if ({d_access, stall, bus_error, wb_en} !== 4'b0010) begin
      n_err++;
      $display("FAIL timeout_abort: d_access=%b stall=%b bus_error=%b wb_en=%b, required 0010",
               d_access, stall, bus_error, wb_en);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({bus_error, wb_en} !== 2'b00) begin
      n_err++; $display("FAIL timeout_pulse_end: bus_error=%b wb_en=%b, required 00", bus_error, wb_en);
    end
    // Next op after an abort completes normally.
    tick();
    mem_load = 1'b1; mem_width = 2'b10; mar = 32'h3002; wr_result = 1'b1; rd_sel = 3'd7;
    sb.push_back('{sel: 3'd7, val: 32'h00000022});
    @(negedge clk);
    tick();
    idle_inputs();
    d_ack = 1'b1; d_data = 32'h11223344;
    @(negedge clk);
    tick();
    d_ack = 1'b0;
    @(negedge clk);
    exp = sb.pop_front();
    n_cmp++;
    if (wb_en !== 1'b1 || wb_sel !== exp.sel || wb_val !== exp.val || bus_error !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_recover: wb_en=%b sel=%0d val=%h err=%b, required 1 %0d %h 0",
               wb_en, wb_sel, wb_val, bus_error, exp.sel, exp.val);
    end
  endtask

  task automatic test_reset_mid_wait();
    wb_t exp;
    tick();
    mem_load = 1'b1; mem_width = 2'b00; mar = 32'h8; wr_result = 1'b1; rd_sel = 3'd1;
    @(negedge clk);
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (d_access !== 1'b1) begin
      n_err++; $display("FAIL rstwait_access: d_access=%b, required 1", d_access);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({d_addr, d_bytesel, d_wr_en, d_wr_val, d_access, stall, wb_en, wb_sel, wb_val, bus_error} !== '0) begin
      n_err++;
      $display("FAIL rstwait_clear: d_addr=%h d_access=%b stall=%b wb_en=%b, required all 0",
               d_addr, d_access, stall, wb_en);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({stall, d_access, wb_en} !== 3'b000) begin
      n_err++; $display("FAIL rstwait_idle: stall=%b d_access=%b wb_en=%b, required 000", stall, d_access, wb_en);
    end
    tick();
    mem_load = 1'b1; mem_width = 2'b00; mar = 32'h0; wr_result = 1'b1; rd_sel = 3'd4;
    sb.push_back('{sel: 3'd4, val: 32'hCAFEF00D});
    @(negedge clk);
    tick();
    idle_inputs();
    d_ack = 1'b1; d_data = 32'hCAFEF00D;
    @(negedge clk);
    n_cmp++;
    if (d_addr !== 32'h0 || d_bytesel !== 4'b1111 || d_access !== 1'b1) begin
      n_err++; $display("FAIL rstwait_bus: addr=%h bs=%b acc=%b, required 0 1111 1", d_addr, d_bytesel, d_access);
    end
    tick();
    d_ack = 1'b0;
    @(negedge clk);
    exp = sb.pop_front();
    n_cmp++;
    if (wb_en !== 1'b1 || wb_sel !== exp.sel || wb_val !== exp.val) begin
      n_err++;
      $display("FAIL rstwait_wb: wb_en=%b sel=%0d val=%h, required 1 %0d %h", wb_en, wb_sel, wb_val, exp.sel, exp.val);
    end
  endtask

`ifdef OLDLAND_MEM_ALIGN_CHECK_EN
  task automatic test_misaligned();
    tick();
    mem_load = 1'b1; mem_width = 2'b00; mar = 32'h4002; wr_result = 1'b1; rd_sel = 3'd2;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL misalign_issue_stall: stall=%b, required 1", stall);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({d_access, bus_error, wb_en, stall} !== 4'b0100) begin
      n_err++;
      $display("FAIL misalign_abort: d_access=%b bus_error=%b wb_en=%b stall=%b, required 0100",
               d_access, bus_error, wb_en, stall);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus_error !== 1'b0) begin
      n_err++; $display("FAIL misalign_pulse_end: bus_error=%b, required 0", bus_error);
    end
  endtask
`else
  task automatic test_misaligned();
    wb_t exp;
    tick();
    mem_load = 1'b1; mem_width = 2'b00; mar = 32'h4002; wr_result = 1'b1; rd_sel = 3'd2;
    sb.push_back('{sel: 3'd2, val: 32'h01020304});
    @(negedge clk);
    tick();
    idle_inputs();
    d_ack = 1'b1; d_data = 32'h01020304;
    @(negedge clk);
    n_cmp++;
    if (d_addr !== 32'h4000 || d_bytesel !== 4'b1111 || d_access !== 1'b1) begin
      n_err++; $display("FAIL unaligned_bus: addr=%h bs=%b acc=%b, required 00004000 1111 1", d_addr, d_bytesel, d_access);
    end
    tick();
    d_ack = 1'b0;
    @(negedge clk);
    exp = sb.pop_front();
    n_cmp++;
    if (wb_en !== 1'b1 || wb_val !== exp.val || wb_sel !== exp.sel || bus_error !== 1'b0) begin
      n_err++;
      $display("FAIL unaligned_wb: wb_en=%b sel=%0d val=%h err=%b, required 1 %0d %h 0",
               wb_en, wb_sel, wb_val, bus_error, exp.sel, exp.val);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nonmem();
    test_load_byte();
    test_store_half();
    test_width_sweep();
    test_timeout();
    test_reset_mid_wait();
    test_misaligned();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
